neuron_writeback: RTL and testbench
===================================

# neuron_writeback

Result write-back unit for the neural accelerator: collects accumulator results from the MAC core at each neuron boundary and applies ReLU, fixed-point rescale and unsigned saturation. It then writes the 8-bit activations into the write port of the neuron dual-port RAM at consecutive addresses from a layer write base. It is the writer counterpart to the address-generator/MAC read path. A small FIFO decouples result arrival from write-port availability.

## Interface
Parameters:
- ACC_W, 16, signed accumulator width from the MAC core
- DATA_W, 8, neuron value width stored in RAM
- ADDR_W, 8, neuron RAM address width
- FRAC_SHIFT, 4, arithmetic right shift applied after ReLU
- FIFO_DEPTH, 4, result FIFO entries (power of two)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle pulse; latches write_base and Nk, begins a layer
- write_base  in  ADDR_W  first RAM address of the layer's outputs
- Nk  in  8  number of neuron results expected in this layer
- acc_in  in  ACC_W  signed accumulator value
- acc_valid  in  1  acc_in is a finished neuron result this cycle
- wr_ready  in  1  neuron RAM write port available this cycle
- wre  out  1  registered write strobe to neuron RAM
- write_address  out  ADDR_W  registered RAM write address
- write_data  out  DATA_W  registered activation value
- busy  out  1  high from accepted start until layer_done
- layer_done  out  1  one-cycle pulse after the final write
- overflow  out  1  sticky; result dropped because FIFO was full

## Operation
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - start latches base and count = Nk; clears the accepted and written counters.
  - Goes to COLLECT, or to DONE if Nk = 0.
  - start outside IDLE is ignored.
- COLLECT:
  - An acc_valid result is pushed into the FIFO when accepted < count and the FIFO is not full.
  - acc_valid with a full FIFO drops the result and sets overflow. The drop still counts as accepted, so the layer terminates.
  - acc_valid after count results have been accepted is ignored, with no overflow.
  - When accepted reaches count, the state goes to DRAIN.
- DRAIN: when written reaches count, the state goes to DONE. Dropped results still advance written-equivalent accounting, so the layer always completes.
- DONE: layer_done = 1 for one cycle, then IDLE.
- Activation is computed at FIFO input, in order:
  - ReLU: a negative acc gives 0.
  - Shift: >>> FRAC_SHIFT.
  - Saturate: values above 2^DATA_W−1 become 255.
- Write pop:
  - Fires in any cycle where the FIFO is non-empty and wr_ready = 1, in COLLECT or DRAIN.
  - Next cycle: wre = 1, write_address = base + index, write_data = head.
  - index counts writes within the layer. Address arithmetic is modulo 2^ADDR_W; base 0xFE with Nk = 4 writes 0xFE, 0xFF, 0x00, 0x01.
- Push and pop in the same cycle are both performed. A full FIFO still blocks a push, even with a simultaneous pop.
- overflow is cleared only by reset.

## Timing
- Reset values:
  - Outputs: wre 0, write_address 0, write_data 0, busy 0, layer_done 0, overflow 0.
  - Internal: FIFO empty, state IDLE.
- Reset mid-layer aborts immediately. No further wre is issued, and no layer_done is pulsed.
- start at cycle t gives busy = 1 at t+1.
- acc_valid at cycle t, with an empty FIFO and wr_ready high at t+1:
  - The result is in the FIFO at t+1.
  - wre = 1 at t+2.
- wr_ready low holds the FIFO, and wre stays 0 in those cycles. wr_ready is sampled in the pop cycle only.
- Sustained throughput is one write per cycle.
- layer_done is asserted the cycle after the final wre.
- busy falls in the same cycle layer_done rises, so the next start is accepted that cycle.
- Nk = 0: start at t gives layer_done at t+2 with no wre.

## Test plan
- Basic layer:
  - Stimulus: base 0x10, Nk 3; acc 0x0120, 0xFF00 (negative), 0x7FFF on consecutive cycles; wr_ready = 1.
  - Response: writes (0x10, 0x12), (0x11, 0x00), (0x12, 0xFF); layer_done one cycle after the third wre.
- Backpressure:
  - Stimulus: Nk 4; wr_ready held 0 while 4 results arrive, then 1.
  - Response: four consecutive wre in order, overflow 0.
- Overflow:
  - Stimulus: Nk 6; wr_ready 0 while 6 results arrive.
  - Response: the first 4 are written after wr_ready rises, overflow = 1, layer_done still pulses.
- Address wrap:
  - Stimulus: base 0xFE, Nk 4.
  - Response: addresses 0xFE, 0xFF, 0x00, 0x01.
- Edge cases:
  - Nk 0: start gives layer_done at t+2 with no wre.
  - start while busy is ignored.
  - Extra acc_valid beyond Nk causes no write.
- Reset mid-DRAIN:
  - Stimulus: reset with 2 FIFO entries pending.
  - Response: no wre after reset, all outputs 0; the next layer is written from its own base correctly.

Source files
------------

// File: rtl/neuron_writeback.sv
// Result write-back for the neural accelerator: ReLU, rescale and saturate each
// MAC result, queue it, and write activations to consecutive neuron RAM addresses.
module neuron_writeback #(
  parameter int ACC_W      = 16,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FRAC_SHIFT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] write_base,
  input  logic [7:0]        Nk,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              acc_valid,
  input  logic              wr_ready,
  output logic              wre,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              layer_done,
  output logic              overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   base_reg;
  logic [7:0]          count_reg;
  logic [7:0]          accepted_reg, accepted_next;
  logic [7:0]          written_reg, written_next;
  logic [7:0]          index_reg;

  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr_reg, rd_ptr_reg;
  logic                fifo_empty, fifo_full;
  logic                accept, push, drop, pop;

  logic signed [ACC_W-1:0] relu_val, shift_val;
  logic [DATA_W-1:0]       act_val;

  // Activation is formed before queuing so the FIFO only stores DATA_W bits.
  always_comb begin
    relu_val  = acc_in[ACC_W-1] ? '0 : signed'(acc_in);
    shift_val = relu_val >>> FRAC_SHIFT;
    act_val   = (|shift_val[ACC_W-1:DATA_W]) ? '1 : shift_val[DATA_W-1:0];
  end

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

  always_comb begin
    accept = (state_reg == COLLECT) && acc_valid && (accepted_reg < count_reg);
    push   = accept && !fifo_full;
    drop   = accept && fifo_full;
    pop    = !fifo_empty && wr_ready &&
             ((state_reg == COLLECT) || (state_reg == DRAIN));
    accepted_next = accepted_reg + 8'(accept);
    // Dropped results count as retired so the layer still terminates.
    written_next  = written_reg + 8'(pop) + 8'(drop);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (Nk == 8'd0) ? DONE : COLLECT;
      COLLECT: if (accepted_next == count_reg) state_next = DRAIN;
      DRAIN:   if (written_next == count_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= act_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      count_reg     <= '0;
      accepted_reg  <= '0;
      written_reg   <= '0;
      index_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      wre           <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      layer_done    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      layer_done   <= (state_reg == DONE);
      wre          <= pop;
      accepted_reg <= accepted_next;
      written_reg  <= written_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        write_address <= base_reg + ADDR_W'(index_reg);
        write_data    <= fifo_mem[rd_ptr_reg[PTR_W-1:0]];
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        index_reg     <= index_reg + 8'd1;
      end
      if (drop) overflow <= 1'b1;
      if ((state_reg == IDLE) && start) begin
        base_reg     <= write_base;
        count_reg    <= Nk;
        accepted_reg <= '0;
        written_reg  <= '0;
        index_reg    <= '0;
      end
    end
  end

  // DONE still reports busy; it drops as layer_done rises.
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_neuron_writeback.sv
// Directed bench for neuron_writeback: logs every RAM write and layer_done,
// then compares against hand-computed addresses, data and cycle timing.
module tb_neuron_writeback;

  logic        clk = 1'b0;
  logic        reset, start, acc_valid, wr_ready;
  logic [7:0]  write_base, Nk;
  logic [15:0] acc_in;
  logic        wre, busy, layer_done, overflow;
  logic [7:0]  write_address, write_data;

  neuron_writeback dut (
    .clk(clk), .reset(reset), .start(start), .write_base(write_base), .Nk(Nk),
    .acc_in(acc_in), .acc_valid(acc_valid), .wr_ready(wr_ready), .wre(wre),
    .write_address(write_address), .write_data(write_data), .busy(busy),
    .layer_done(layer_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         wr_cyc_q[$];
  logic [7:0] wr_addr_q[$], wr_data_q[$];
  int         done_cyc_q[$];
  logic [7:0] exp_addr_q[$], exp_data_q[$];

  always @(negedge clk) begin
    if (wre) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(write_address);
      wr_data_q.push_back(write_data);
      $display("cycle %0d: write addr 0x%02h data 0x%02h", cyc, write_address, write_data);
    end
    if (layer_done) begin
      done_cyc_q.push_back(cyc);
      $display("cycle %0d: layer_done", cyc);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    done_cyc_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
  endtask

  task automatic start_layer(input logic [7:0] base, input logic [7:0] n);
    write_base = base; Nk = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    acc_in = v; acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (done_cyc_q.size() == 0 && k < limit) begin
      tick();
      k++;
    end
    repeat (4) tick();
    check({tag, "_done_pulses"}, done_cyc_q.size(), 1);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_write_count"}, wr_addr_q.size(), exp_addr_q.size());
    n = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr_q[i]);
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data_q[i]);
    end
    if (wr_cyc_q.size() > 0 && done_cyc_q.size() > 0)
      check({tag, "_done_cycle"}, done_cyc_q[0], wr_cyc_q[wr_cyc_q.size()-1] + 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wre"}, wre, 0);
    check({tag, "_addr"}, write_address, 0);
    check({tag, "_data"}, write_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, layer_done, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; acc_valid = 1'b0; wr_ready = 1'b1;
    acc_in = '0; write_base = '0; Nk = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Basic layer, also checks busy and first-write latency.
    clear_log();
    start_layer(8'h10, 8'd3);
    check("basic_busy", busy, 1);
    c0 = cyc;
    send(16'h0120); send(16'hFF00); send(16'h7FFF);
    expect_write(8'h10, 8'h12); expect_write(8'h11, 8'h00); expect_write(8'h12, 8'hFF);
    wait_done("basic", 40);
    compare_writes("basic");
    if (wr_cyc_q.size() > 0) check("basic_latency", wr_cyc_q[0], c0 + 2);
    check("basic_busy_after", busy, 0);

    // Backpressure: four results queue up, then drain back to back.
    clear_log();
    wr_ready = 1'b0;
    start_layer(8'h40, 8'd4);
    send(16'h0010); send(16'h0FF0); send(16'h0800); send(16'h0F00);
    repeat (3) tick();
    check("bp_held", wr_addr_q.size(), 0);
    wr_ready = 1'b1;
    expect_write(8'h40, 8'h01); expect_write(8'h41, 8'hFF);
    expect_write(8'h42, 8'h80); expect_write(8'h43, 8'hF0);
    wait_done("bp", 40);
    compare_writes("bp");
    for (int i = 1; i < wr_cyc_q.size(); i++)
      check($sformatf("bp_consecutive%0d", i), wr_cyc_q[i], wr_cyc_q[0] + i);
    check("bp_overflow", overflow, 0);

    // Overflow: six results into a four-entry FIFO with the port blocked.
    clear_log();
    wr_ready = 1'b0;
    start_layer(8'h80, 8'd6);
    send(16'h0100); send(16'h0200); send(16'h0300);
    send(16'h0400); send(16'h0500); send(16'h0600);
    repeat (2) tick();
    check("ovf_flag", overflow, 1);
    wr_ready = 1'b1;
    expect_write(8'h80, 8'h10); expect_write(8'h81, 8'h20);
    expect_write(8'h82, 8'h30); expect_write(8'h83, 8'h40);
    wait_done("ovf", 40);
    compare_writes("ovf");
    check("ovf_sticky", overflow, 1);

    // Address wrap, with an ignored start and an extra result past Nk.
    clear_log();
    start_layer(8'hFE, 8'd4);
    start_layer(8'h20, 8'd9);
    send(16'h0010); send(16'h0020); send(16'h0030); send(16'h0040); send(16'h0050);
    expect_write(8'hFE, 8'h01); expect_write(8'hFF, 8'h02);
    expect_write(8'h00, 8'h03); expect_write(8'h01, 8'h04);
    wait_done("wrap", 40);
    compare_writes("wrap");

    // Empty layer.
    clear_log();
    c0 = cyc;
    start_layer(8'h33, 8'd0);
    wait_done("nk0", 20);
    check("nk0_writes", wr_addr_q.size(), 0);
    if (done_cyc_q.size() > 0) check("nk0_done_cycle", done_cyc_q[0], c0 + 2);

    // Reset with two entries pending, then a fresh layer.
    clear_log();
    wr_ready = 1'b0;
    start_layer(8'h50, 8'd2);
    send(16'h0100); send(16'h0200);
    tick();
    reset = 1'b1; wr_ready = 1'b1;
    tick();
    check_idle_outputs("rst_mid");
    reset = 1'b0;
    repeat (5) tick();
    check("rst_no_write", wr_addr_q.size(), 0);
    check("rst_no_done", done_cyc_q.size(), 0);
    clear_log();
    start_layer(8'h60, 8'd2);
    send(16'h0050); send(16'hFFFF);
    expect_write(8'h60, 8'h05); expect_write(8'h61, 8'h00);
    wait_done("post_rst", 40);
    compare_writes("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
